// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the issue-stage hazard scoreboard.
// Slot fields are sized for the largest supported configuration; narrower
// instances zero-extend into them.
package hazard_scoreboard_pkg;

  localparam int unsigned NREG_DFLT = 31;
  localparam int unsigned NREG_MAX  = 31;
  localparam int unsigned DEPTH_MAX = 8;
  localparam int unsigned LATW_MAX  = 4;

  typedef struct packed {
    logic                valid;
    logic [NREG_MAX-1:0] wmask;
    logic [LATW_MAX-1:0] lat;
  } slot_t;

  // One pipeline step: remaining forwarding latency counts down to zero.
  function automatic slot_t slot_age(slot_t s);
    slot_t r;
    r = s;
    if (s.lat != '0) begin
      r.lat = s.lat - LATW_MAX'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Compares one in-flight slot against the issuing instruction's source mask.
module hazard_match
  import hazard_scoreboard_pkg::*;
(
  input  slot_t               slot,
  input  logic                live,
  input  logic [NREG_MAX-1:0] rmask,
  output logic                hit_c
);

  // Slots whose result is already forwardable (lat 0) never block issue.
  assign hit_c = live & slot.valid & (slot.lat != '0) & (|(rmask & slot.wmask));

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage register hazard scoreboard: tracks in-flight destination masks
// with per-slot forwarding latency and stalls dependent issue.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = NREG_DFLT,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned LATW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [NREG-1:0] issue_rmask,
  input  logic [NREG-1:0] issue_wmask,
  input  logic [LATW-1:0] issue_lat,
  input  logic            hold,
  input  logic            flush,
  output logic            stall,
  output logic [NREG-1:0] pending_mask,
  output logic [15:0]     stall_count
);

  slot_t               slots [DEPTH];
  logic [DEPTH-1:0]    hit;
  logic [NREG_MAX-1:0] rmask_ext;
  logic                hazard_c;
  logic                advance_c;
  logic                accept_c;
  slot_t               new_slot_c;

  assign rmask_ext = NREG_MAX'(issue_rmask);

  // The retiring slot writes back on this edge, so its result is bypassed.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    hazard_match u_match (
      .slot  (slots[g]),
      .live  (g != (DEPTH - 1)),
      .rmask (rmask_ext),
      .hit_c (hit[g])
    );
  end

  assign hazard_c  = issue_valid & (|hit);
  assign advance_c = ~hold & ~flush;
  assign accept_c  = issue_valid & ~hazard_c;
  assign stall     = (hazard_c | hold) & ~flush;

  always_comb begin
    new_slot_c = '0;
    if (accept_c) begin
      new_slot_c.valid = 1'b1;
      new_slot_c.wmask = NREG_MAX'(issue_wmask);
      new_slot_c.lat   = LATW_MAX'(issue_lat);
    end
  end

  always_comb begin
    logic [NREG_MAX-1:0] pend;
    pend = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slots[k].valid) begin
        pend = pend | slots[k].wmask;
      end
    end
    pending_mask = NREG'(pend);
  end

  // Shift register of in-flight slots; reset and flush clear everything.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        slots[k] <= '0;
      end
    end else if (advance_c) begin
      slots[0] <= new_slot_c;
      for (int k = 1; k < DEPTH; k++) begin
        slots[k] <= slot_age(slots[k-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (hazard_c && advance_c && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed scoreboard bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  localparam int unsigned NREG  = 31;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LATW  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic [NREG-1:0] issue_rmask;
  logic [NREG-1:0] issue_wmask;
  logic [LATW-1:0] issue_lat;
  logic            hold;
  logic            flush;
  logic            stall;
  logic [NREG-1:0] pending_mask;
  logic [15:0]     stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .LATW(LATW)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rmask  (issue_rmask),
    .issue_wmask  (issue_wmask),
    .issue_lat    (issue_lat),
    .hold         (hold),
    .flush        (flush),
    .stall        (stall),
    .pending_mask (pending_mask),
    .stall_count  (stall_count)
  );

  // Reference: each accepted instruction remembers the advance count at issue;
  // its slot position and remaining latency follow from elapsed advances.
  typedef struct {
    logic [NREG-1:0] wm;
    int              lat;
    int              iss;
  } ent_t;

  typedef struct {
    logic            stall;
    logic [NREG-1:0] pend;
    logic [15:0]     cnt;
  } exp_t;

  ent_t inflight[$];
  exp_t expq[$];
  int   adv;
  int   m_cnt;
  int   checks;
  int   errors;

  function automatic bit model_hazard(logic iv, logic [NREG-1:0] rm);
    if (!iv) return 1'b0;
    foreach (inflight[i]) begin
      int k;
      k = adv - inflight[i].iss;
      if (k < int'(DEPTH) - 1 && inflight[i].lat - k > 0 && (rm & inflight[i].wm) != '0)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p;
    p = '0;
    foreach (inflight[i]) p = p | inflight[i].wm;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Apply one cycle of stimulus, queue the expected response, step the model.
  task automatic drive(input logic iv, input logic [NREG-1:0] rm, input logic [NREG-1:0] wm,
                       input int lat, input logic h, input logic f, input logic r,
                       output bit haz);
    exp_t e;
    @(posedge clk);
    #1;
    issue_valid = iv;
    issue_rmask = rm;
    issue_wmask = wm;
    issue_lat   = LATW'(lat);
    hold        = h;
    flush       = f;
    reset       = r;
    haz = model_hazard(iv, rm);
    if (!r) begin
      e.stall = (haz | h) & ~f;
      e.pend  = model_pending();
      e.cnt   = 16'(m_cnt);
      expq.push_back(e);
    end
    if (r) begin
      inflight.delete();
      m_cnt = 0;
    end else if (f) begin
      inflight.delete();
    end else if (!h) begin
      if (haz && m_cnt < 65535) m_cnt++;
      adv++;
      if (iv && !haz) inflight.push_back('{wm: wm, lat: lat, iss: adv});
      while (inflight.size() > 0 && adv - inflight[0].iss >= int'(DEPTH))
        void'(inflight.pop_front());
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      check("stall", 32'(stall), 32'(e.stall));
      check("pending_mask", 32'(pending_mask), 32'(e.pend));
      check("stall_count", 32'(stall_count), 32'(e.cnt));
    end
  end

  function automatic logic [NREG-1:0] bitm(input int b);
    logic [NREG-1:0] one;
    one = NREG'(1);
    return one << b;
  endfunction

  initial begin
    bit haz;
    int cnt_before;
    int sat_hits;
    int guard;
    checks = 0; errors = 0; adv = 0; m_cnt = 0;
    reset = 1'b1; issue_valid = 1'b0; issue_rmask = '0; issue_wmask = '0;
    issue_lat = '0; hold = 1'b0; flush = 1'b0;

    drive(0, '0, '0, 0, 0, 0, 1, haz);
    drive(0, '0, '0, 0, 1, 0, 0, haz);
    check("reset_stall_eq_hold", 32'(stall), 32'd1);
    check("reset_pending", 32'(pending_mask), 32'd0);
    check("reset_count", 32'(stall_count), 32'd0);

    // Load-use: one stall, then accepted.
    drive(1, '0, bitm(4), 1, 0, 0, 0, haz);
    drive(1, bitm(4), '0, 0, 0, 0, 0, haz);
    check("load_use_stall", 32'(stall), 32'd1);
    drive(1, bitm(4), '0, 0, 0, 0, 0, haz);
    check("load_use_accept", 32'(stall), 32'd0);
    check("load_use_count", 32'(stall_count), 32'd1);

    // ALU back-to-back: no stall.
    drive(1, '0, bitm(6), 0, 0, 0, 0, haz);
    drive(1, bitm(6), bitm(7), 0, 0, 0, 0, haz);
    check("alu_b2b_stall", 32'(stall), 32'd0);
    drive(0, '0, '0, 0, 0, 0, 0, haz);
    check("alu_b2b_pending", 32'(pending_mask & (bitm(6) | bitm(7))), 32'(bitm(6) | bitm(7)));

    // Hold during a pending load-use.
    drive(1, '0, bitm(5), 1, 0, 0, 0, haz);
    cnt_before = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, bitm(5), '0, 0, 1, 0, 0, haz);
      check("hold_stall", 32'(stall), 32'd1);
      check("hold_count", 32'(stall_count), 32'(cnt_before));
    end
    drive(1, bitm(5), '0, 0, 0, 0, 0, haz);
    check("hold_release_stall", 32'(stall), 32'd1);
    drive(1, bitm(5), '0, 0, 0, 0, 0, haz);
    check("hold_resolve", 32'(stall), 32'd0);
    check("hold_resolve_count", 32'(stall_count), 32'(cnt_before + 1));

    // Flush with three valid slots; presented instruction dropped.
    drive(0, '0, '0, 0, 0, 0, 1, haz);
    drive(1, '0, bitm(1), 0, 0, 0, 0, haz);
    drive(1, '0, bitm(2), 2, 0, 0, 0, haz);
    drive(1, '0, bitm(3), 3, 0, 0, 0, haz);
    drive(1, bitm(2), bitm(9), 1, 1, 1, 0, haz);
    check("flush_stall", 32'(stall), 32'd0);
    drive(0, '0, '0, 0, 0, 0, 0, haz);
    check("flush_pending", 32'(pending_mask), 32'd0);

    // Reset mid-stream with occupied slots and a nonzero count.
    drive(1, '0, bitm(10), 3, 0, 0, 0, haz);
    drive(1, bitm(10), bitm(11), 2, 0, 0, 0, haz);
    drive(1, bitm(10), bitm(11), 2, 0, 0, 0, haz);
    drive(1, '0, bitm(12), 1, 0, 0, 1, haz);
    drive(0, '0, '0, 0, 0, 0, 0, haz);
    check("midreset_pending", 32'(pending_mask), 32'd0);
    check("midreset_count", 32'(stall_count), 32'd0);

    // Randomized traffic on a small register window to provoke overlaps.
    for (int i = 0; i < 3000; i++) begin
      logic [NREG-1:0] rm, wm;
      int r;
      rm = NREG'($urandom_range(0, 63));
      wm = NREG'($urandom_range(0, 63));
      r  = int'($urandom_range(0, 99));
      drive(($urandom_range(0, 3) != 0), rm, wm, int'($urandom_range(0, 7)),
            (r < 10), (r >= 10 && r < 14), (r == 99), haz);
    end

    // Saturation: a self-dependent long-latency op keeps re-triggering hazards.
    drive(0, '0, '0, 0, 0, 0, 1, haz);
    sat_hits = 0;
    guard = 0;
    while (sat_hits < 65540 && guard < 90000) begin
      drive(1, bitm(7), bitm(7), 7, 0, 0, 0, haz);
      if (haz) sat_hits++;
      guard++;
    end
    check("sat_hits_reached", 32'(sat_hits), 32'd65540);
    drive(0, '0, '0, 0, 0, 0, 0, haz);
    check("sat_count", 32'(stall_count), 32'hFFFF);

    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
